ht_preamble_seq: RTL and testbench
==================================

// Module: ht_preamble_seq
// PURPOSE
//  Sequences the HT-STF and HT-LTF frequency-domain ROMs into the TX IFFT input stream.
//  - On start, emits one HT-STF symbol, then N HT-LTF symbols, each 64 subcarriers (32-bit I/Q).
//  - Output is a valid/ready stream. Sits between the preamble ROMs and the IFFT/CP-insert stage.
// PARAMETERS
//  IQ_W     16  width of each of I and Q (dout = {I,Q}, 2*IQ_W bits)
//  ADDR_W   7   ROM address width (bit 6 is always driven 0)
//  N_SC     64  subcarriers per symbol
// PORTS
//  clk           in   1   clock
//  rstn          in   1   asynchronous active-low reset
//  start         in   1   1-cycle pulse: begin sequence; ignored while busy
//  abort         in   1   synchronous abort: return to IDLE, no done
//  ht_ltf_num    in   3   HT-LTF count, sampled at start; 0->1, >4 clamped to 4
//  stf_rom_addr  out  7   HT-STF ROM address (ROM is combinational)
//  stf_rom_dout  in   32  HT-STF ROM data {I,Q}
//  ltf_rom_addr  out  7   HT-LTF ROM address
//  ltf_rom_dout  in   32  HT-LTF ROM data {I,Q}
//  iq_data       out  32  subcarrier value {I[31:16],Q[15:0]}
//  iq_valid      out  1   iq_data valid
//  iq_ready      in   1   downstream accepts when iq_valid&&iq_ready
//  sym_first     out  1   iq_data is subcarrier 0 of a symbol
//  sym_last      out  1   iq_data is subcarrier 63 of a symbol
//  seg_is_ltf    out  1   0 = HT-STF symbol, 1 = HT-LTF symbol
//  busy          out  1   high from the cycle after start until done/abort
//  done          out  1   1-cycle pulse after the final sample handshake
// BEHAVIOUR
//  - Reset: all outputs 0. State IDLE. Counters 0.
//  - States: IDLE -> STF (64 loads) -> LTF (64*N loads) -> DONE (1 cycle, done=1) -> IDLE.
//  - The abort input forces IDLE from any state next cycle:
//    iq_valid=0, busy=0, done stays 0. abort has priority over start.
//  - Counters: sc_cnt[5:0] (subcarrier), ltf_cnt[1:0] (LTF symbol index 0..N-1).
//  - Both ROM addresses are driven {1'b0, map(sc_cnt)}.
//  - Load condition: ld = in-sequence && (!iq_valid || iq_ready).
//    - On ld: register ROM data into iq_data, set iq_valid, increment sc_cnt.
//    - sc_cnt wraps 63->0, advancing the symbol. Throughput 1 sample/clk when iq_ready=1.
//  - Latency: start at cycle T -> busy=1 and first address at T+1 -> iq_valid=1 at T+2.
//  - Stall: while iq_valid&&!iq_ready, iq_data/sym_first/sym_last/seg_is_ltf stay stable.
//    Counters and addresses hold during the stall.
//  - After the last load, no further ld. FSM waits for the final handshake.
//    DONE then follows; iq_valid falls the cycle after the final handshake.
//  - HT-LTF polarity follows P-matrix row 0: [+1,-1,+1,+1]. Symbol ltf_cnt==1 is negated.
//    - Negation is per I and Q, two's complement, saturating: -(-32768) = 32767.
//    - Other symbols pass through unchanged. HT-STF is never negated.
//  - sym_first is set when the loaded sample's sc_cnt==0; sym_last when sc_cnt==63.
//  - Total samples = 64*(1+N): N=1 -> 128, N=4 -> 320.
//  - start while busy or in DONE: ignored. start in the same cycle as done's IDLE return: accepted.
//  - Reset mid-sequence: immediate return to reset values. No partial done.
// CONFIGURATION
//  PREAMBLE_FFT_SHIFT_EN
//  - Undefined: map(k)=k. Output order is subcarrier -32..31 (address 0..63).
//  - Defined: map(k)=k^6'h20. Output order is IFFT natural, subcarrier 0..31 then -32..-1
//    (address 32..63, 0..31).
//  sym_first/sym_last refer to output position, not address, in both modes.
// STRUCTURE
//  - Shared package ht_preamble_pkg:
//    - state encoding (IDLE/STF/LTF/DONE), N_SC, IQ_W
//    - P_ROW0 = 4'b0010 (1 = negate, per LTF index)
//    - MAX_HT_LTF = 4
//  - Sub-module iq_negate_sat: combinational saturating negate of one IQ_W-bit value.
//    Instantiated twice (I, Q).
//  - Everything else (FSM, counters, output register) stays in this module.
// TESTING
//  1. N=1, iq_ready=1, no shift: start -> 128 samples.
//     - Sample 4 = 32'hC000C000 (STF).
//     - sym_last on samples 63 and 127. done 1 cycle after sample 127.
//  2. Shift defined: first STF sample is address 32 = 0.
//     - Sample 8 = address 40 = 32'h40004000. Sample 32 = address 0.
//  3. N=2, LTF ROM addr 6 = 32'h40000000: second LTF symbol sample 6 = 32'hC0000000.
//     ROM forced to 32'h80008000 there -> 32'h7FFF7FFF.
//  4. Backpressure: iq_ready toggles 1,0,0,1 pattern.
//     - Data is stable across stalls. 128 unique handshakes. No sample dropped or duplicated.
//  5. abort at sample 70 -> iq_valid=0 and busy=0 next cycle, no done.
//     A new start then begins again at sample 0.
//  6. ht_ltf_num=0 -> 128 samples. ht_ltf_num=7 -> 320 samples.
//     start pulsed mid-sequence -> ignored, count unchanged.
//     rstn low at sample 50 -> all outputs 0.

Source files
------------

// File: rtl/ht_preamble_pkg.sv
// rtl/ht_preamble_pkg.sv - shared constants, state encoding and subcarrier mapping for the HT preamble sequencer
// Contents:
//   IQ_W, N_SC, ADDR_W, MAX_HT_LTF  widths and limits
//   P_ROW0                          per-LTF-symbol negate mask (1 = negate)
//   state_t                         sequencer state encoding
//   sc_map()                        subcarrier counter -> ROM address map
// Config macro: PREAMBLE_FFT_SHIFT_EN (defined: IFFT-natural order, address = k ^ 32)
package ht_preamble_pkg;

  localparam int IQ_W       = 16;
  localparam int N_SC       = 64;
  localparam int ADDR_W     = 7;
  localparam int MAX_HT_LTF = 4;

  // P-matrix row 0 is [+1,-1,+1,+1]; bit i set means LTF symbol i is negated.
  localparam logic [MAX_HT_LTF-1:0] P_ROW0 = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STF,
    ST_LTF,
    ST_DONE
  } state_t;

  function automatic logic [5:0] sc_map(input logic [5:0] k);
`ifdef PREAMBLE_FFT_SHIFT_EN
    return k ^ 6'h20;
`else
    return k;
`endif
  endfunction

endpackage

// File: rtl/ht_preamble_seq_if.sv
// rtl/ht_preamble_seq_if.sv - IQ output stream bundle between the preamble sequencer and the IFFT stage
// Signals:
//   iq_data     {I,Q} subcarrier value
//   iq_valid    iq_data valid
//   iq_ready    downstream accepts when iq_valid && iq_ready
//   sym_first   sample is output position 0 of a symbol
//   sym_last    sample is output position 63 of a symbol
//   seg_is_ltf  0 = HT-STF symbol, 1 = HT-LTF symbol
// Modports: master (sequencer), slave (IFFT side)
interface ht_preamble_seq_if;
  import ht_preamble_pkg::*;

  logic [2*IQ_W-1:0] iq_data;
  logic              iq_valid;
  logic              iq_ready;
  logic              sym_first;
  logic              sym_last;
  logic              seg_is_ltf;

  modport master (
    output iq_data, iq_valid, sym_first, sym_last, seg_is_ltf,
    input  iq_ready
  );

  modport slave (
    input  iq_data, iq_valid, sym_first, sym_last, seg_is_ltf,
    output iq_ready
  );

endinterface

// File: rtl/iq_negate_sat.sv
// rtl/iq_negate_sat.sv - combinational saturating two's complement negate of one I or Q component
// Ports:
//   din   in  W  signed input
//   dout  out W  -din, with the most negative value mapped to the most positive
module iq_negate_sat #(
  parameter int W = 16
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};

  // -MIN_V is not representable, so it clips to MAX_V.
  assign dout = (din == MIN_V) ? MAX_V : -din;

endmodule

// File: rtl/ht_preamble_seq.sv
// rtl/ht_preamble_seq.sv - sequences HT-STF and HT-LTF ROM contents into the TX IFFT input stream
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   start                     1-cycle pulse, begins a sequence when idle
//   abort                     synchronous return to idle, no done
//   ht_ltf_num[2:0]           HT-LTF symbol count, sampled at start (0->1, >4->4)
//   stf_rom_addr/stf_rom_dout HT-STF ROM (combinational read)
//   ltf_rom_addr/ltf_rom_dout HT-LTF ROM (combinational read)
//   iq                        output stream (ht_preamble_seq_if.master)
//   busy                      sequence in progress
//   done                      1-cycle pulse after the final sample handshake
// Config macro: PREAMBLE_FFT_SHIFT_EN (IFFT-natural subcarrier order)
module ht_preamble_seq
  import ht_preamble_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2:0]           ht_ltf_num,
  output logic [ADDR_W-1:0]    stf_rom_addr,
  input  logic [2*IQ_W-1:0]    stf_rom_dout,
  output logic [ADDR_W-1:0]    ltf_rom_addr,
  input  logic [2*IQ_W-1:0]    ltf_rom_dout,
  ht_preamble_seq_if.master    iq,
  output logic                 busy,
  output logic                 done
);

  state_t            state, state_nxt;
  logic [5:0]        sc_cnt;
  logic [1:0]        ltf_cnt;
  logic [1:0]        ltf_last;
  logic [1:0]        n_m1;
  logic              drain;
  logic              in_seq, ld, sym_wrap, seq_end, hs;
  logic              neg_en;
  logic [2*IQ_W-1:0] rom_sel, ld_data;
  logic [IQ_W-1:0]   neg_i, neg_q;

  // Index of the last LTF symbol after clamping the requested count to 1..MAX_HT_LTF.
  always_comb begin
    n_m1 = 2'd0;
    if (ht_ltf_num == 3'd0)
      n_m1 = 2'd0;
    else if (ht_ltf_num > 3'(MAX_HT_LTF))
      n_m1 = 2'(MAX_HT_LTF - 1);
    else
      n_m1 = 2'(ht_ltf_num - 3'd1);
  end

  // drain marks "last sample loaded, waiting for its handshake": no more loads.
  assign in_seq   = ((state == ST_STF) || (state == ST_LTF)) && !drain;
  assign hs       = iq.iq_valid && iq.iq_ready;
  assign ld       = in_seq && (!iq.iq_valid || iq.iq_ready);
  assign sym_wrap = ld && (sc_cnt == 6'(N_SC - 1));
  assign seq_end  = sym_wrap && (state == ST_LTF) && (ltf_cnt == ltf_last);

  assign stf_rom_addr = in_seq ? {1'b0, sc_map(sc_cnt)} : '0;
  assign ltf_rom_addr = in_seq ? {1'b0, sc_map(sc_cnt)} : '0;

  assign rom_sel = (state == ST_LTF) ? ltf_rom_dout : stf_rom_dout;
  assign neg_en  = (state == ST_LTF) && P_ROW0[ltf_cnt];

  iq_negate_sat #(.W(IQ_W)) u_neg_i (.din(rom_sel[2*IQ_W-1:IQ_W]), .dout(neg_i));
  iq_negate_sat #(.W(IQ_W)) u_neg_q (.din(rom_sel[IQ_W-1:0]),      .dout(neg_q));

  assign ld_data = neg_en ? {neg_i, neg_q} : rom_sel;

  assign busy = (state == ST_STF) || (state == ST_LTF);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_STF;
      ST_STF:  if (sym_wrap) state_nxt = ST_LTF;
      ST_LTF:  if (drain && hs) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sc_cnt        <= '0;
      ltf_cnt       <= '0;
      ltf_last      <= '0;
      drain         <= 1'b0;
      iq.iq_valid   <= 1'b0;
      iq.iq_data    <= '0;
      iq.sym_first  <= 1'b0;
      iq.sym_last   <= 1'b0;
      iq.seg_is_ltf <= 1'b0;
    end else if (abort) begin
      sc_cnt        <= '0;
      ltf_cnt       <= '0;
      drain         <= 1'b0;
      iq.iq_valid   <= 1'b0;
      iq.iq_data    <= '0;
      iq.sym_first  <= 1'b0;
      iq.sym_last   <= 1'b0;
      iq.seg_is_ltf <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        ltf_last <= n_m1;
        sc_cnt   <= '0;
        ltf_cnt  <= '0;
        drain    <= 1'b0;
      end
      if (ld) begin
        iq.iq_valid   <= 1'b1;
        iq.iq_data    <= ld_data;
        iq.sym_first  <= (sc_cnt == 6'd0);
        iq.sym_last   <= (sc_cnt == 6'(N_SC - 1));
        iq.seg_is_ltf <= (state == ST_LTF);
        sc_cnt        <= sc_cnt + 6'd1;
        if (sym_wrap && (state == ST_LTF)) begin
          if (seq_end) drain   <= 1'b1;
          else         ltf_cnt <= ltf_cnt + 2'd1;
        end
      end else if (hs) begin
        iq.iq_valid <= 1'b0;
      end
      if (state == ST_DONE) begin
        drain   <= 1'b0;
        ltf_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ht_preamble_seq.sv
// tb/tb_ht_preamble_seq.sv - self-checking bench for ht_preamble_seq
module tb_ht_preamble_seq;
  import ht_preamble_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        first;
    logic        last;
    logic        seg;
  } samp_t;

  typedef struct {
    int n_in;
    int mode;     // 0 ready=1, 1 pattern 1,0,0,1, 2 random
    int mid;      // cycle index of a mid-sequence start pulse, -1 none
    int exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  ht_ltf_num = 3'd0;
  logic [6:0]  stf_rom_addr, ltf_rom_addr;
  logic [31:0] stf_rom_dout, ltf_rom_dout;
  logic        busy, done;

  logic [31:0] stf_mem [64];
  logic [31:0] ltf_mem [64];

  ht_preamble_seq_if iq_if ();

  assign stf_rom_dout = stf_mem[stf_rom_addr[5:0]];
  assign ltf_rom_dout = ltf_mem[ltf_rom_addr[5:0]];

  ht_preamble_seq dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .abort        (abort),
    .ht_ltf_num   (ht_ltf_num),
    .stf_rom_addr (stf_rom_addr),
    .stf_rom_dout (stf_rom_dout),
    .ltf_rom_addr (ltf_rom_addr),
    .ltf_rom_dout (ltf_rom_dout),
    .iq           (iq_if.master),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    rdy_mode = 0;
  int    rcyc = 0;
  samp_t got_q[$];
  samp_t exp_q[$];
  int    done_total = 0;
  int    stall_bad = 0;
  logic  prev_stall = 1'b0;
  samp_t prev_s;

  // Ready driver.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: iq_if.iq_ready = 1'b1;
      1: iq_if.iq_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
      default: iq_if.iq_ready = 1'($urandom % 2);
    endcase
    rcyc++;
  end

  // Monitor: collect handshakes, count done pulses, watch stall stability.
  always @(negedge clk) begin
    samp_t cur;
    cur = {iq_if.iq_data, iq_if.sym_first, iq_if.sym_last, iq_if.seg_is_ltf};
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!iq_if.iq_valid || cur != prev_s)) stall_bad++;
      if (iq_if.iq_valid && iq_if.iq_ready) got_q.push_back(cur);
      if (done) done_total++;
      prev_stall = iq_if.iq_valid && !iq_if.iq_ready;
      prev_s = cur;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Output position -> ROM address, from the subcarrier ordering rule.
  function automatic logic [5:0] out_addr(input int p);
`ifdef PREAMBLE_FFT_SHIFT_EN
    return (p < 32) ? 6'(p + 32) : 6'(p - 32);
`else
    return 6'(p);
`endif
  endfunction

  function automatic logic [15:0] neg_sat(input logic [15:0] v);
    int x;
    x = -int'($signed(v));
    if (x > 32767) x = 32767;
    return 16'(x);
  endfunction

  task automatic build_model(input int n_in);
    int nn;
    int p_row[4] = '{1, -1, 1, 1};
    samp_t s;
    nn = (n_in == 0) ? 1 : (n_in > 4) ? 4 : n_in;
    exp_q.delete();
    for (int sym = 0; sym <= nn; sym++) begin
      for (int p = 0; p < 64; p++) begin
        if (sym == 0) s.data = stf_mem[out_addr(p)];
        else begin
          s.data = ltf_mem[out_addr(p)];
          if (p_row[sym-1] < 0) s.data = {neg_sat(s.data[31:16]), neg_sat(s.data[15:0])};
        end
        s.first = (p == 0);
        s.last  = (p == 63);
        s.seg   = (sym != 0);
        exp_q.push_back(s);
      end
    end
  endtask

  function automatic samp_t got_at(input int i);
    samp_t z = '0;
    if (i < got_q.size()) return got_q[i];
    return z;
  endfunction

  task automatic run_seq(input int n_in, input int mode, input int mid, input int exp_cnt,
                         input string tag, output int base);
    int dbase, sbase, bad, ng;
    build_model(n_in);
    rdy_mode = mode;
    base = got_q.size();
    dbase = done_total;
    sbase = stall_bad;
    @(posedge clk); #1;
    ht_ltf_num = 3'(n_in);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ht_ltf_num = 3'($urandom);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (done_total != dbase) break;
      start = (c == mid);
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, " done_pulses"}, 64'(done_total - dbase), 64'd1);
    ng = got_q.size() - base;
    chk({tag, " sample_count"}, 64'(ng), 64'(exp_cnt));
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < ng; i++)
      if (got_q[base+i] != exp_q[i]) begin
        bad = i;
        break;
      end
    chk({tag, " first_bad_index"}, 64'(bad), 64'(-1));
    chk({tag, " stall_hold"}, 64'(stall_bad - sbase), 64'd0);
  endtask

  task automatic wait_samples(input int base, input int n, input string tag);
    int ok;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (got_q.size() - base >= n) begin
        ok = 1;
        break;
      end
    end
    chk({tag, " reached"}, 64'(ok), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[7];
  int   b, dbase, p6;

  initial begin
    vecs[0] = '{1, 0, -1, 128};
    vecs[1] = '{2, 1, -1, 192};
    vecs[2] = '{0, 0, -1, 128};
    vecs[3] = '{7, 2, -1, 320};
    vecs[4] = '{3, 2, 40, 256};
    vecs[5] = '{4, 1, -1, 320};
    vecs[6] = '{2, 0, 100, 192};

    for (int i = 0; i < 64; i++) begin
      stf_mem[i] = $urandom;
      ltf_mem[i] = $urandom;
    end
    stf_mem[0]  = 32'h0000_0000;
    stf_mem[4]  = 32'hC000_C000;
    stf_mem[40] = 32'h4000_4000;
    ltf_mem[6]  = 32'h4000_0000;
    ltf_mem[10] = 32'h8000_0001;
    p6 = 6;
`ifdef PREAMBLE_FFT_SHIFT_EN
    p6 = 38;
`endif

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("reset iq_valid", 64'(iq_if.iq_valid), 64'd0);
    chk("reset iq_data", 64'(iq_if.iq_data), 64'd0);
    chk("reset flags", 64'({iq_if.sym_first, iq_if.sym_last, iq_if.seg_is_ltf}), 64'd0);
    chk("reset busy_done", 64'({busy, done}), 64'd0);
    chk("reset addrs", 64'({stf_rom_addr, ltf_rom_addr}), 64'd0);

    // Latency: start at T, busy and first address at T+1, valid at T+2.
    build_model(1);
    rdy_mode = 0;
    dbase = done_total;
    b = got_q.size();
    @(posedge clk); #1;
    ht_ltf_num = 3'd1;
    start = 1'b1;
    @(negedge clk);
    chk("lat T busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("lat T+1 busy", 64'(busy), 64'd1);
    chk("lat T+1 valid", 64'(iq_if.iq_valid), 64'd0);
    chk("lat T+1 addr", 64'(stf_rom_addr), 64'({1'b0, out_addr(0)}));
    @(negedge clk);
    chk("lat T+2 valid", 64'(iq_if.iq_valid), 64'd1);
    chk("lat T+2 sample", 64'({iq_if.iq_data, iq_if.sym_first}), 64'({exp_q[0].data, 1'b1}));
    wait_samples(b, 128, "lat drain");
    @(negedge clk);
    chk("lat done after last", 64'(done_total - dbase), 64'd1);
    chk("lat valid low at done", 64'(iq_if.iq_valid), 64'd0);
    repeat (3) @(posedge clk);

    // Table-driven sequences.
    for (int v = 0; v < 7; v++)
      run_seq(vecs[v].n_in, vecs[v].mode, vecs[v].mid, vecs[v].exp_cnt, $sformatf("vec%0d", v), b);

    // Specific samples of a single-LTF sequence.
    run_seq(1, 0, -1, 128, "t1", b);
`ifdef PREAMBLE_FFT_SHIFT_EN
    chk("t1 sample8", 64'(got_at(b+8).data), 64'h4000_4000);
    chk("t1 sample32", 64'(got_at(b+32).data), 64'h0);
`else
    chk("t1 sample4", 64'(got_at(b+4).data), 64'hC000_C000);
`endif
    chk("t1 last63", 64'(got_at(b+63).last), 64'd1);
    chk("t1 last127", 64'(got_at(b+127).last), 64'd1);
    chk("t1 first64", 64'({got_at(b+64).first, got_at(b+64).seg}), 64'd3);

    // Negated second LTF symbol, including saturation.
    run_seq(2, 0, -1, 192, "t3a", b);
    chk("t3a ltf1 neg", 64'(got_at(b+128+p6).data), 64'hC000_0000);
    chk("t3a ltf0 pass", 64'(got_at(b+64+p6).data), 64'h4000_0000);
    ltf_mem[6] = 32'h8000_8000;
    run_seq(2, 2, -1, 192, "t3b", b);
    chk("t3b ltf1 sat", 64'(got_at(b+128+p6).data), 64'h7FFF_7FFF);

    // Abort after 70 samples: no done, then a clean restart.
    rdy_mode = 0;
    dbase = done_total;
    b = got_q.size();
    @(posedge clk); #1;
    ht_ltf_num = 3'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_samples(b, 70, "abort");
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort valid", 64'(iq_if.iq_valid), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort no done", 64'(done_total - dbase), 64'd0);
    run_seq(1, 0, -1, 128, "after abort", b);

    // Reset mid-sequence.
    rdy_mode = 2;
    dbase = done_total;
    b = got_q.size();
    @(posedge clk); #1;
    ht_ltf_num = 3'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_samples(b, 50, "rst");
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("rst outputs", 64'({iq_if.iq_valid, iq_if.sym_first, iq_if.sym_last, iq_if.seg_is_ltf, busy, done}), 64'd0);
    chk("rst data", 64'(iq_if.iq_data), 64'd0);
    chk("rst addrs", 64'({stf_rom_addr, ltf_rom_addr}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst no done", 64'(done_total - dbase), 64'd0);
    run_seq(3, 1, -1, 256, "after rst", b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
